mini_alu_exec_unit: RTL and testbench

//  Parametrised execute stage for the MiniAlu processor family; successor of the fixed 16-bit core.

---
 rtl/mini_alu_exec_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_mini_alu_exec_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mini_alu_exec_unit.sv
// MiniAlu execute stage: register file, single-cycle ALU/branch/LED ops,
// serial signed shift-add IMUL with stall, branch squash and status flags.
module mini_alu_exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LED_W  = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    iInstrValid,
  input  logic [4+3*ADDR_W-1:0]   iInstruction,
  output logic                    oInstrReady,
  output logic                    oBranchTaken,
  output logic [ADDR_W-1:0]       oBranchTarget,
  output logic [LED_W-1:0]        oLed,
  output logic                    oOverflow,
  output logic                    oIllegal
);

  localparam int unsigned INSTR_W  = 4 + 3 * ADDR_W;
  localparam int unsigned IMM_W    = 2 * ADDR_W;
  localparam int unsigned PROD_W   = 2 * DATA_W;
  localparam int unsigned CNT_W    = $clog2(DATA_W);
  localparam int unsigned RF_DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LED  = 4'd1;
  localparam logic [3:0] OP_BLE  = 4'd2;
  localparam logic [3:0] OP_STO  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_SMUL = 4'd7;
  localparam logic [3:0] OP_IMUL = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  logic [DATA_W-1:0] rf_q [RF_DEPTH];

  logic [1:0]        state_q,  state_d;
  logic [3:0]        op_q,     op_d;
  logic [ADDR_W-1:0] dst_q,    dst_d;
  logic [ADDR_W-1:0] src1_q,   src1_d;
  logic [ADDR_W-1:0] src0_q,   src0_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PROD_W-1:0] acc_q,    acc_d;
  logic [PROD_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic              ready_q,  ready_d;
  logic              br_q,     br_d;
  logic [ADDR_W-1:0] tgt_q,    tgt_d;
  logic              ill_q,    ill_d;
  logic [LED_W-1:0]  led_q,    led_d;
  logic              ovf_q,    ovf_d;

  // Incoming instruction fields and handshake
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_dst, in_src1, in_src0;
  logic              accept_c, squash_c;

  assign in_op    = iInstruction[INSTR_W-1 -: 4];
  assign in_dst   = iInstruction[3*ADDR_W-1 -: ADDR_W];
  assign in_src1  = iInstruction[2*ADDR_W-1 -: ADDR_W];
  assign in_src0  = iInstruction[ADDR_W-1:0];
  assign accept_c = iInstrValid & ready_q;
  // A branch executing this cycle kills whatever is accepted alongside it
  assign squash_c = br_q;

  // Execute-stage operands and results
  logic [DATA_W-1:0]        a_c, b_c, imm_c, sum_c, diff_c, shl_c, sar_c;
  logic signed [IMM_W-1:0]  imm_raw;
  logic [PROD_W-1:0]        a_ext, b_ext, smul_c;
  logic [PROD_W-1:0]        term_c, acc_next;
  logic                     mul_last;
  logic                     wr_en_c;
  logic [ADDR_W-1:0]        wr_addr_c;
  logic [DATA_W-1:0]        wr_data_c;
  logic                     ovf_set_c;
  logic [DATA_W-1:0]        fwd1_c, fwd0_c;
  logic                     in_taken_c;

  assign a_c     = rf_q[src1_q];
  assign b_c     = rf_q[src0_q];
  assign imm_raw = {src1_q, src0_q};
  assign imm_c   = DATA_W'(imm_raw);
  assign sum_c   = a_c + b_c;
  assign diff_c  = a_c - b_c;
  assign shl_c   = a_c << b_c[3:0];
  assign sar_c   = DATA_W'($signed(a_c) >>> b_c[3:0]);
  assign a_ext   = {{DATA_W{a_c[DATA_W-1]}}, a_c};
  assign b_ext   = {{DATA_W{b_c[DATA_W-1]}}, b_c};
  assign smul_c  = a_ext * b_ext;

  // Serial multiply step: MSB of the multiplier carries negative weight
  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_W'(DATA_W - 1));
  assign term_c   = mplier_q[0] ? mcand_q : '0;
  assign acc_next = mul_last ? (acc_q - term_c) : (acc_q + term_c);

  // Register-file write port selection and overflow detection
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = dst_q;
    wr_data_c = '0;
    ovf_set_c = 1'b0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_STO:  begin wr_en_c = 1'b1; wr_data_c = imm_c; end
        OP_ADD:  begin
          wr_en_c   = 1'b1;
          wr_data_c = sum_c;
          ovf_set_c = (a_c[DATA_W-1] == b_c[DATA_W-1]) && (sum_c[DATA_W-1] != a_c[DATA_W-1]);
        end
        OP_SUB:  begin
          wr_en_c   = 1'b1;
          wr_data_c = diff_c;
          ovf_set_c = (a_c[DATA_W-1] != b_c[DATA_W-1]) && (diff_c[DATA_W-1] != a_c[DATA_W-1]);
        end
        OP_SMUL: begin
          wr_en_c   = 1'b1;
          wr_data_c = smul_c[DATA_W-1:0];
          ovf_set_c = !((&smul_c[PROD_W-1:DATA_W-1]) || !(|smul_c[PROD_W-1:DATA_W-1]));
        end
        OP_SHL:  begin wr_en_c = 1'b1; wr_data_c = shl_c; end
        OP_SAR:  begin wr_en_c = 1'b1; wr_data_c = sar_c; end
        default: ;
      endcase
    end else if (mul_last) begin
      wr_en_c   = 1'b1;
      wr_data_c = acc_next[DATA_W-1:0];
      ovf_set_c = !((&acc_next[PROD_W-1:DATA_W-1]) || !(|acc_next[PROD_W-1:DATA_W-1]));
    end
  end

  // Operands for the incoming instruction see the write landing on this edge
  assign fwd1_c     = (wr_en_c && (wr_addr_c == in_src1)) ? wr_data_c : rf_q[in_src1];
  assign fwd0_c     = (wr_en_c && (wr_addr_c == in_src0)) ? wr_data_c : rf_q[in_src0];
  assign in_taken_c = (in_op == OP_JMP) ||
                      ((in_op == OP_BLE) && ($signed(fwd1_c) <= $signed(fwd0_c)));

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src1_d   = src1_q;
    src0_d   = src0_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ready_d  = ready_q;
    br_d     = 1'b0;
    tgt_d    = '0;
    ill_d    = 1'b0;
    led_d    = led_q;
    ovf_d    = ovf_q | ovf_set_c;

    if ((state_q == S_EXEC) && (op_q == OP_LED)) begin
      led_d = a_c[LED_W-1:0];
    end

    case (state_q)
      S_IDLE, S_EXEC: begin
        if (accept_c) begin
          op_d   = squash_c ? OP_NOP : in_op;
          dst_d  = in_dst;
          src1_d = in_src1;
          src0_d = in_src0;
          br_d   = !squash_c && in_taken_c;
          tgt_d  = (!squash_c && in_taken_c) ? in_dst : '0;
          ill_d  = !squash_c && (in_op > OP_SAR);
          if (!squash_c && (in_op == OP_IMUL)) begin
            state_d  = S_MUL;
            ready_d  = 1'b0;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{DATA_W{fwd1_c[DATA_W-1]}}, fwd1_c};
            mplier_d = fwd0_c;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      dst_q    <= '0;
      src1_q   <= '0;
      src0_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ready_q  <= 1'b1;
      br_q     <= 1'b0;
      tgt_q    <= '0;
      ill_q    <= 1'b0;
      led_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src1_q   <= src1_d;
      src0_q   <= src0_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ready_q  <= ready_d;
      br_q     <= br_d;
      tgt_q    <= tgt_d;
      ill_q    <= ill_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
    end
  end

  // Register file write; contents survive reset
  always_ff @(posedge Clock) begin
    if (wr_en_c) begin
      rf_q[wr_addr_c] <= wr_data_c;
    end
  end

  assign oInstrReady   = ready_q;
  assign oBranchTaken  = br_q;
  assign oBranchTarget = tgt_q;
  assign oLed          = led_q;
  assign oOverflow     = ovf_q;
  assign oIllegal      = ill_q;

endmodule

// File: tb/tb_mini_alu_exec_unit.sv
// Directed bench for mini_alu_exec_unit with hand-computed expectations.
module tb_mini_alu_exec_unit;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LED_W  = 8;

  logic                  Clock;
  logic                  Reset;
  logic                  iInstrValid;
  logic [4+3*ADDR_W-1:0] iInstruction;
  logic                  oInstrReady;
  logic                  oBranchTaken;
  logic [ADDR_W-1:0]     oBranchTarget;
  logic [LED_W-1:0]      oLed;
  logic                  oOverflow;
  logic                  oIllegal;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  mini_alu_exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LED_W(LED_W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iInstrValid  (iInstrValid),
    .iInstruction (iInstruction),
    .oInstrReady  (oInstrReady),
    .oBranchTaken (oBranchTaken),
    .oBranchTarget(oBranchTarget),
    .oLed         (oLed),
    .oOverflow    (oOverflow),
    .oIllegal     (oIllegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] d,
                                     input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'd3, d, imm};
  endfunction

  // Present one instruction and hold it until accepted; returns 1ns after the accept edge
  task automatic send(input logic [27:0] ins);
    int n;
    n = 0;
    iInstrValid  = 1'b1;
    iInstruction = ins;
    @(negedge Clock);
    while (!oInstrReady && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(posedge Clock);
    #1;
    iInstrValid = 1'b0;
  endtask

  // Count cycles with oInstrReady low, bounded
  task automatic count_stall(output int n);
    n = 0;
    @(negedge Clock);
    while (!oInstrReady && n < 60) begin
      n++;
      @(negedge Clock);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int start;
    int stall;
    Reset        = 1'b1;
    iInstrValid  = 1'b0;
    iInstruction = '0;

    // T1 reset
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("t1_ready", 32'(oInstrReady), 32'd1);
    check("t1_led", 32'(oLed), 32'd0);
    check("t1_ovf", 32'(oOverflow), 32'd0);
    check("t1_branch", 32'(oBranchTaken), 32'd0);
    check("t1_illegal", 32'(oIllegal), 32'd0);
    step();

    // T2 ALU throughput and results
    start = cyc;
    send(sto(8'd1, 16'd5));
    send(sto(8'd2, 16'hFFFD));
    send(mk(4'd4, 8'd3, 8'd2, 8'd1));
    send(mk(4'd5, 8'd4, 8'd2, 8'd1));
    send(mk(4'd1, 8'd0, 8'd3, 8'd0));
    send(mk(4'd1, 8'd0, 8'd4, 8'd0));
    check("t2_cycles", 32'(cyc - start), 32'd6);
    check("t2_led_add", 32'(oLed), 32'h02);
    step();
    check("t2_led_sub", 32'(oLed), 32'hF8);
    check("t2_r3", 32'(dut.rf_q[3]), 32'h0002);
    check("t2_r4", 32'(dut.rf_q[4]), 32'hFFF8);
    send(mk(4'd9,  8'd5, 8'd2, 8'd1));
    send(mk(4'd10, 8'd6, 8'd2, 8'd1));
    send(mk(4'd7,  8'd7, 8'd2, 8'd1));
    step();
    check("t2_shl", 32'(dut.rf_q[5]), 32'hFFA0);
    check("t2_sar", 32'(dut.rf_q[6]), 32'hFFFF);
    check("t2_smul", 32'(dut.rf_q[7]), 32'hFFF1);
    check("t2_ovf", 32'(oOverflow), 32'd0);

    // T3 IMUL with stall
    send(sto(8'd1, 16'hFFF9));
    send(sto(8'd2, 16'd300));
    send(mk(4'd8, 8'd3, 8'd2, 8'd1));
    count_stall(stall);
    check("t3_stall", 32'(stall), 32'd16);
    check("t3_r3", 32'(dut.rf_q[3]), 32'hF7CC);
    send(mk(4'd1, 8'd0, 8'd3, 8'd0));
    send(mk(4'd7, 8'd6, 8'd2, 8'd1));
    check("t3_led", 32'(oLed), 32'hCC);
    step();
    check("t3_smul", 32'(dut.rf_q[6]), 32'hF7CC);
    check("t3_ovf", 32'(oOverflow), 32'd0);

    // T4 branch taken with squash, then not taken
    send(sto(8'd5, 16'h0055));
    send(sto(8'd1, 16'd3));
    send(sto(8'd2, 16'd3));
    send(mk(4'd2, 8'h20, 8'd2, 8'd1));
    check("t4_taken", 32'(oBranchTaken), 32'd1);
    check("t4_target", 32'(oBranchTarget), 32'h20);
    send(sto(8'd5, 16'd9));
    check("t4_pulse_end", 32'(oBranchTaken), 32'd0);
    step();
    check("t4_squash_r5", 32'(dut.rf_q[5]), 32'h0055);
    send(sto(8'd2, 16'd4));
    send(mk(4'd2, 8'h20, 8'd2, 8'd1));
    check("t4_not_taken", 32'(oBranchTaken), 32'd0);
    send(sto(8'd5, 16'd9));
    step();
    check("t4_r5_written", 32'(dut.rf_q[5]), 32'h0009);
    send(mk(4'd6, 8'h44, 8'd0, 8'd0));
    check("t4_jmp", 32'(oBranchTaken), 32'd1);
    check("t4_jmp_target", 32'(oBranchTarget), 32'h44);
    step();
    check("t4_jmp_end", 32'(oBranchTaken), 32'd0);

    // T5 overflow and illegal opcode
    send(sto(8'd1, 16'h7FFF));
    send(sto(8'd2, 16'd1));
    send(mk(4'd4, 8'd3, 8'd1, 8'd2));
    step();
    check("t5_r3", 32'(dut.rf_q[3]), 32'h8000);
    check("t5_ovf", 32'(oOverflow), 32'd1);
    send(mk(4'd13, 8'd0, 8'd0, 8'd0));
    check("t5_illegal", 32'(oIllegal), 32'd1);
    step();
    check("t5_illegal_end", 32'(oIllegal), 32'd0);
    send(mk(4'd1, 8'd0, 8'd2, 8'd0));
    step();
    check("t5_led", 32'(oLed), 32'h01);
    check("t5_ovf_sticky", 32'(oOverflow), 32'd1);

    // T6 reset during IMUL
    send(sto(8'd3, 16'h1234));
    send(mk(4'd8, 8'd3, 8'd1, 8'd2));
    repeat (4) @(posedge Clock);
    #2;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("t6_ready", 32'(oInstrReady), 32'd1);
    check("t6_ovf", 32'(oOverflow), 32'd0);
    check("t6_r3", 32'(dut.rf_q[3]), 32'h1234);
    step();

    // IMUL overflow with source equal to destination
    send(sto(8'd1, 16'h4000));
    send(mk(4'd8, 8'd1, 8'd1, 8'd1));
    count_stall(stall);
    check("t7_stall", 32'(stall), 32'd16);
    check("t7_r1", 32'(dut.rf_q[1]), 32'h0000);
    check("t7_ovf", 32'(oOverflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
